// File: rtl/lut_eval_engine.sv
// lut_eval_engine: N_CH runtime-reloadable truth tables evaluated in parallel.
// Optional table parity check on load: define LUT_PARITY_EN.
`default_nettype none

// +--------------------------------------------------------------------------+
// | Module      : lut_eval_engine                                            |
// | Description : Registered multi-channel LUT evaluator with a serial table |
// |               load port (shadow register, atomic commit). Optional       |
// |               macro LUT_PARITY_EN adds an even-parity check on commit.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module lut_eval_engine #(
    parameter int                   N_IN       = 6,
    parameter int                   N_CH       = 2,
    parameter logic [(1<<N_IN)-1:0] TABLE_INIT = '0
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     in_valid_i,
    input  logic [N_IN-1:0]                          in_data_i,
    output logic                                     in_ready_o,
    output logic                                     out_valid_o,
    output logic [N_CH-1:0]                          out_data_o,
    input  logic                                     cfg_start_i,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch_i,
    input  logic                                     cfg_valid_i,
    input  logic                                     cfg_bit_i,
    output logic                                     cfg_busy_o,
    output logic                                     cfg_done_o,
    input  logic                                     cfg_par_i,
    output logic                                     cfg_err_o
);

    localparam int DEPTH = 1 << N_IN;
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DEPTH-1:0]    table_q [N_CH];
    logic [DEPTH-1:0]    shadow_q, shadow_d, shadow_next;
    logic [N_IN-1:0]     cnt_q, cnt_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic                par_q, par_d;
    logic                done_q;
    logic                out_valid_q;
    logic [N_CH-1:0]     out_data_q, out_data_d;
    logic                load_end;
    logic                commit;
    logic                par_ok;
    logic                accept;

    assign in_ready_o  = (state_q == ST_RUN);
    assign cfg_busy_o  = (state_q == ST_LOAD);
    assign cfg_done_o  = done_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign accept      = in_valid_i & in_ready_o;

    // Shadow contents including the bit arriving this cycle; used for the
    // final-beat commit so the last bit does not need an extra cycle.
    always_comb begin
        shadow_next        = shadow_q;
        shadow_next[cnt_q] = cfg_bit_i;
    end

`ifdef LUT_PARITY_EN
    logic err_q;

    assign par_ok    = ((^shadow_next) == par_q);
    assign cfg_err_o = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (load_end && !par_ok) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_par;

    assign par_ok     = 1'b1;
    assign cfg_err_o  = 1'b0;
    assign unused_par = par_q;
`endif

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        ch_d     = ch_q;
        par_d    = par_q;
        load_end = 1'b0;
        commit   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (cfg_start_i) begin
                    state_d  = ST_LOAD;
                    shadow_d = '0;
                    cnt_d    = '0;
                    ch_d     = cfg_ch_i;
                    par_d    = cfg_par_i;
                end
            end
            ST_LOAD: begin
                // A restart takes priority over a coincident final beat.
                if (cfg_start_i) begin
                    shadow_d = '0;
                    cnt_d    = '0;
                    ch_d     = cfg_ch_i;
                    par_d    = cfg_par_i;
                end else if (cfg_valid_i) begin
                    shadow_d = shadow_next;
                    cnt_d    = cnt_q + N_IN'(1);
                    if (cnt_q == N_IN'(DEPTH - 1)) begin
                        load_end = 1'b1;
                        commit   = par_ok;
                        state_d  = ST_RUN;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        out_data_d = out_data_q;
        if (accept) begin
            for (int k = 0; k < N_CH; k++) begin
                out_data_d[k] = table_q[k][in_data_i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            shadow_q    <= '0;
            cnt_q       <= '0;
            ch_q        <= '0;
            par_q       <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            cnt_q       <= cnt_d;
            ch_q        <= ch_d;
            par_q       <= par_d;
            done_q      <= load_end;
            out_valid_q <= accept;
            out_data_q  <= out_data_d;
        end
    end

    // Latched channel numbers at or above N_CH match no table and are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                table_q[k] <= TABLE_INIT;
            end
        end else if (commit) begin
            for (int k = 0; k < N_CH; k++) begin
                if (ch_q == CH_W'(k)) begin
                    table_q[k] <= shadow_next;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lut_eval_engine.sv
// Directed self-checking bench for lut_eval_engine (N_IN=6, N_CH=2, TABLE_INIT=0).
`default_nettype none

module tb_lut_eval_engine;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [5:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_data;
    logic       cfg_start;
    logic [0:0] cfg_ch;
    logic       cfg_valid;
    logic       cfg_bit;
    logic       cfg_busy;
    logic       cfg_done;
    logic       cfg_par;
    logic       cfg_err;

    int n_cmp;
    int n_err;
    int busy_cnt;

    lut_eval_engine #(
        .N_IN       (6),
        .N_CH       (2),
        .TABLE_INIT (64'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .cfg_start_i (cfg_start),
        .cfg_ch_i    (cfg_ch),
        .cfg_valid_i (cfg_valid),
        .cfg_bit_i   (cfg_bit),
        .cfg_busy_o  (cfg_busy),
        .cfg_done_o  (cfg_done),
        .cfg_par_i   (cfg_par),
        .cfg_err_o   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic eval(input string tag, input logic [5:0] d, input logic [1:0] exp);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        check({tag, "_vld"}, 64'(out_valid), 64'h1);
        check(tag, 64'(out_data), 64'(exp));
    endtask

    task automatic start_load(input logic ch, input logic par);
        cfg_start = 1'b1;
        cfg_ch    = ch;
        cfg_par   = par;
        tick();
        cfg_start = 1'b0;
        busy_cnt  = int'(cfg_busy);
    endtask

    task automatic send_bits(input logic [63:0] val, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                cfg_valid = 1'b0;
                tick();
                busy_cnt += int'(cfg_busy);
            end
            cfg_valid = 1'b1;
            cfg_bit   = val[i];
            tick();
            busy_cnt += int'(cfg_busy);
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        busy_cnt  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        cfg_start = 1'b0;
        cfg_ch    = '0;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        cfg_par   = 1'b0;

        #2;
        check("rst_ready", 64'(in_ready), 64'h1);
        check("rst_ovld",  64'(out_valid), 64'h0);
        check("rst_odata", 64'(out_data), 64'h0);
        check("rst_busy",  64'(cfg_busy), 64'h0);
        check("rst_done",  64'(cfg_done), 64'h0);
        check("rst_err",   64'(cfg_err), 64'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        eval("init_2a", 6'h2A, 2'b00);

        // ch0 load, continuous beats
        start_load(1'b0, ^64'h8000_0000_0000_0001);
        check("ld0_ready", 64'(in_ready), 64'h0);
        send_bits(64'h8000_0000_0000_0001, 64, 1'b0);
        check("ld0_busycyc", 64'(busy_cnt), 64'd64);
        check("ld0_done", 64'(cfg_done), 64'h1);
        check("ld0_busy_off", 64'(cfg_busy), 64'h0);
        tick();
        check("ld0_done_pulse", 64'(cfg_done), 64'h0);
        eval("ch0_00", 6'h00, 2'b01);
        eval("ch0_3f", 6'h3F, 2'b01);
        eval("ch0_01", 6'h01, 2'b00);

        // ch1 load with a gap before every beat
        start_load(1'b1, ^64'hFFFF_FFFF_FFFF_FFFF);
        send_bits(64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b1);
        check("ld1_busycyc", 64'(busy_cnt), 64'd128);
        check("ld1_done", 64'(cfg_done), 64'h1);
        tick();
        eval("ch1_00", 6'h00, 2'b11);
        eval("ch1_05", 6'h05, 2'b10);
        eval("ch1_3f", 6'h3F, 2'b11);
        tick();
        check("hold_vld", 64'(out_valid), 64'h0);
        check("hold_data", 64'(out_data), 64'h3);

        // partial load, dropped request, then restart with zeros
        start_load(1'b1, 1'b0);
        send_bits(64'h0000_0000_0000_03FF, 10, 1'b0);
        in_valid = 1'b1;
        in_data  = 6'h00;
        tick();
        in_valid = 1'b0;
        check("drop_vld", 64'(out_valid), 64'h0);
        check("drop_busy", 64'(cfg_busy), 64'h1);
        start_load(1'b1, 1'b0);
        send_bits(64'h0, 64, 1'b0);
        check("rstrt_done", 64'(cfg_done), 64'h1);
        eval("rstrt_05", 6'h05, 2'b00);
        eval("rstrt_00", 6'h00, 2'b01);
        eval("rstrt_3f", 6'h3F, 2'b01);

        // accept coincident with cfg_start; restart beats the final beat
        in_valid  = 1'b1;
        in_data   = 6'h00;
        cfg_start = 1'b1;
        cfg_ch    = 1'b0;
        cfg_par   = 1'b0;
        tick();
        in_valid  = 1'b0;
        cfg_start = 1'b0;
        check("cowrk_vld", 64'(out_valid), 64'h1);
        check("cowrk_data", 64'(out_data), 64'h1);
        check("cowrk_busy", 64'(cfg_busy), 64'h1);
        send_bits(64'hFFFF_FFFF_FFFF_FFFF, 63, 1'b0);
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        cfg_start = 1'b1;
        cfg_ch    = 1'b0;
        cfg_par   = 1'b1;
        tick();
        cfg_valid = 1'b0;
        cfg_start = 1'b0;
        check("race_done", 64'(cfg_done), 64'h0);
        check("race_busy", 64'(cfg_busy), 64'h1);
        send_bits(64'h1, 64, 1'b0);
        check("race_ld_done", 64'(cfg_done), 64'h1);
        eval("race_00", 6'h00, 2'b01);
        eval("race_3f", 6'h3F, 2'b00);
        eval("race_01", 6'h01, 2'b00);

        // asynchronous reset in the middle of a load
        start_load(1'b1, 1'b0);
        send_bits(64'hFFFF_FFFF_FFFF_FFFF, 5, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", 64'(cfg_busy), 64'h0);
        check("arst_ready", 64'(in_ready), 64'h1);
        check("arst_odata", 64'(out_data), 64'h0);
        tick();
        rst = 1'b0;
        tick();
        eval("arst_00", 6'h00, 2'b00);
        eval("arst_3f", 6'h3F, 2'b00);

`ifdef LUT_PARITY_EN
        start_load(1'b0, 1'b1);
        send_bits(64'h3, 64, 1'b0);
        check("par_bad_done", 64'(cfg_done), 64'h1);
        check("par_bad_err", 64'(cfg_err), 64'h1);
        tick();
        eval("par_bad_00", 6'h00, 2'b00);
        eval("par_bad_01", 6'h01, 2'b00);
        start_load(1'b0, 1'b0);
        send_bits(64'h3, 64, 1'b0);
        check("par_ok_done", 64'(cfg_done), 64'h1);
        check("par_ok_err", 64'(cfg_err), 64'h1);
        tick();
        eval("par_ok_00", 6'h00, 2'b01);
        eval("par_ok_01", 6'h01, 2'b01);
        eval("par_ok_02", 6'h02, 2'b00);
        rst = 1'b1;
        #1;
        check("par_rst_err", 64'(cfg_err), 64'h0);
        tick();
        rst = 1'b0;
        tick();
`else
        start_load(1'b0, 1'b1);
        send_bits(64'h3, 64, 1'b0);
        check("nopar_done", 64'(cfg_done), 64'h1);
        check("nopar_err", 64'(cfg_err), 64'h0);
        tick();
        eval("nopar_01", 6'h01, 2'b01);
        eval("nopar_02", 6'h02, 2'b00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
